divider: RTL
============

Name: divider

Overview:
- Iterative signed 64/64 divider using the same op_start/op_clear/op_done handshake as the team's multiplier. It is the inverse arithmetic unit and sits beside the multiplier in the datapath.
- Computes quotient and remainder one bit per cycle using radix-2 non-restoring division.
- Output is packed as result = {remainder, quotient}, so consumers use the same 128-bit result bus as the multiplier.

Parameters:
WIDTH, 64, operand width in bits; result width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
dividend  input  WIDTH  signed two's-complement dividend
divisor  input  WIDTH  signed two's-complement divisor
op_start  input  1  start request, sampled only in IDLE
op_clear  input  1  abort/clear, highest priority after reset
op_done  output  1  registered; high while in DONE
div_by_zero  output  1  registered; high in DONE when divisor was 0
result  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, registered

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; count=0; all internal registers 0.
  - result=0, op_done=0, div_by_zero=0.
- States: IDLE, CALC, FIX, DONE (2-bit encoding).
- IDLE:
  - result held at 0.
  - If op_start=1 at a clock edge (edge E0):
    - latch |dividend| and |divisor|;
    - latch the sign flags sq = dividend[MSB]^divisor[MSB] and sr = dividend[MSB];
    - latch the raw dividend;
    - count=0; go to CALC.
  - Operand changes after E0 have no effect.
- CALC:
  - If the latched divisor is 0: at edge E1 go directly to DONE with:
    - quotient = all ones;
    - remainder = raw dividend;
    - div_by_zero=1.
  - Otherwise, one non-restoring iteration per edge, E1..E64:
    - the partial remainder P is WIDTH+1 bits, signed;
    - shift {P, Q} left by 1;
    - if P was non-negative, P = P - D, else P = P + D;
    - new Q LSB = ~P[MSB];
    - count increments; after the 64th iteration (count=63) go to FIX.
- FIX, one edge (E65):
  - if P<0, P = P + D (remainder restore);
  - apply signs: quotient negated if sq=1, remainder negated if sr=1;
  - load result; go to DONE; op_done=1 after E65.
- Latency: op_done is visible 65 cycles after the op_start sample edge, or 1 cycle for divide-by-zero. Latency is fixed with no early termination, so verification can use exact cycle counts.
- DONE:
  - result, op_done and div_by_zero are held.
  - op_start is ignored.
  - op_clear=1 → IDLE, with result=0, op_done=0 and div_by_zero=0 at that edge.
- Semantics:
  - truncation toward zero;
  - remainder sign = dividend sign;
  - |remainder| < |divisor|;
  - dividend = quotient*divisor + remainder.
- Overflow: most-negative ÷ -1 gives quotient = 0x8000_0000_0000_0000 (wraps), remainder = 0, no flag.
- op_clear in CALC or FIX: abort at the next edge → IDLE, with result=0 and count=0.
- op_clear and op_start both high in IDLE: op_clear wins and the state stays IDLE.
- Reset asserted mid-operation: immediate return to the reset values listed above.
- Arithmetic:
  - all add/sub uses one shared (WIDTH+1)-bit adder with carry-in for subtraction (~D + 1);
  - the sign-fix negations share the same adder across FIX, with one extra adder allowed.

Test Plan:
- 100 ÷ 7, op_start pulse → op_done after 65 cycles; result = {64'd2, 64'd14}; div_by_zero=0.
- -100 ÷ 7 → quotient 0xFFFF_FFFF_FFFF_FFF2 (-14), remainder 0xFFFF_FFFF_FFFF_FFFE (-2); 100 ÷ -7 → quotient -14, remainder 2.
- 12345 ÷ 0 → op_done 1 cycle after start; quotient 0xFFFF_FFFF_FFFF_FFFF; remainder 12345; div_by_zero=1.
- 0x8000_0000_0000_0000 ÷ -1 → quotient 0x8000_0000_0000_0000, remainder 0. Also 5 ÷ 9 → quotient 0, remainder 5.
- Start 100 ÷ 7, assert op_clear at cycle 30 → IDLE next edge with result=0 and op_done never high. A fresh start of 81 ÷ 9 then gives {0, 9} after 65 cycles.
- In DONE, toggle op_start and change the operands → result is unchanged. op_clear → result=0 and op_done=0. Assert reset_n=0 mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative signed WIDTH/WIDTH divider. It computes one quotient bit per clock
//   using radix-2 non-restoring division on operand magnitudes. A final FIX
//   cycle restores the remainder and applies the signs. The result is packed as
//   {remainder, quotient}, so it shares the multiplier's 2*WIDTH result bus.
//
//   Semantics: the quotient truncates toward zero, and the remainder takes the
//   sign of the dividend. Dividing the most negative value by -1 wraps the
//   quotient to the most negative value and gives a remainder of 0. Dividing by
//   zero gives a quotient of all ones, returns the dividend as the remainder and
//   raises div_by_zero.
//
//   Latency is fixed: op_done rises WIDTH+1 cycles after the op_start sample
//   edge, or 1 cycle after it when the divisor is zero.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   dividend     in   WIDTH    signed dividend, sampled with op_start in IDLE
//   divisor      in   WIDTH    signed divisor, sampled with op_start in IDLE
//   op_start     in   1        start request, only honoured in IDLE
//   op_clear     in   1        abort / acknowledge, returns to IDLE
//   op_done      out  1        registered, high while in DONE
//   div_by_zero  out  1        registered, high in DONE after a zero divisor
//   result       out  2*WIDTH  registered {remainder, quotient}
// -----------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               op_start,
    input  logic               op_clear,
    output logic               op_done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ---------------------------------------------------------------- state
    state_t               r_state;
    logic [CW-1:0]        r_count;
    logic [WIDTH:0]       r_p;          // signed partial remainder
    logic [WIDTH-1:0]     r_q;          // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]     r_d;          // divisor magnitude
    logic [WIDTH-1:0]     r_dividend;   // raw dividend, returned on divide-by-zero
    logic                 r_sq;         // quotient sign
    logic                 r_sr;         // remainder sign
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_op_done;
    logic                 r_dbz;

    state_t               w_state_next;
    logic [CW-1:0]        w_count_next;
    logic [WIDTH:0]       w_p_next;
    logic [WIDTH-1:0]     w_q_next;
    logic [WIDTH-1:0]     w_d_next;
    logic [WIDTH-1:0]     w_dividend_next;
    logic                 w_sq_next;
    logic                 w_sr_next;
    logic [2*WIDTH-1:0]   w_result_next;
    logic                 w_op_done_next;
    logic                 w_dbz_next;

    // ----------------------------------------------------- shared main adder
    // In CALC it performs the non-restoring add/subtract on the shifted
    // partial remainder. Subtraction is ~D with a carry-in of 1. In FIX it
    // performs the conditional remainder restore (P + D, or P + 0).
    logic [WIDTH:0]       w_d_ext;
    logic [WIDTH:0]       w_p_shift;
    logic [WIDTH:0]       w_add_a;
    logic [WIDTH:0]       w_add_b;
    logic                 w_add_cin;
    logic [WIDTH:0]       w_sum;

    assign w_d_ext   = {1'b0, r_d};
    assign w_p_shift = {r_p[WIDTH-1:0], r_q[WIDTH-1]};

    always_comb begin
        w_add_a   = w_p_shift;
        w_add_b   = r_p[WIDTH] ? w_d_ext : ~w_d_ext;
        w_add_cin = ~r_p[WIDTH];
        if (r_state == S_FIX) begin
            w_add_a   = r_p;
            w_add_b   = r_p[WIDTH] ? w_d_ext : '0;
            w_add_cin = 1'b0;
        end
    end

    assign w_sum = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_add_cin};

    // ------------------------------------------------------------ negators
    // Two negators serve two purposes. In IDLE they form the operand
    // magnitudes. In FIX they apply the quotient and remainder signs.
    // Neither use overlaps the other, so the input muxes are all they cost.
    logic [WIDTH-1:0]     w_neg_a_in;
    logic [WIDTH-1:0]     w_neg_a;
    logic [WIDTH-1:0]     w_neg_b_in;
    logic [WIDTH-1:0]     w_neg_b;
    logic [WIDTH-1:0]     w_rem_mag;

    assign w_rem_mag  = w_sum[WIDTH-1:0];
    assign w_neg_a_in = (r_state == S_IDLE) ? dividend : r_q;
    assign w_neg_b_in = (r_state == S_IDLE) ? divisor  : w_rem_mag;
    assign w_neg_a    = ~w_neg_a_in + WIDTH'(1);
    assign w_neg_b    = ~w_neg_b_in + WIDTH'(1);

    logic [WIDTH-1:0]     w_abs_dividend;
    logic [WIDTH-1:0]     w_abs_divisor;
    logic [WIDTH-1:0]     w_quot_signed;
    logic [WIDTH-1:0]     w_rem_signed;

    // The magnitude of the most negative value wraps to itself. Read as
    // unsigned, that is still the correct magnitude.
    assign w_abs_dividend = dividend[WIDTH-1] ? w_neg_a : dividend;
    assign w_abs_divisor  = divisor[WIDTH-1]  ? w_neg_b : divisor;
    assign w_quot_signed  = r_sq ? w_neg_a : r_q;
    assign w_rem_signed   = r_sr ? w_neg_b : w_rem_mag;

    // ------------------------------------------------ next-state / datapath
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_p_next        = r_p;
        w_q_next        = r_q;
        w_d_next        = r_d;
        w_dividend_next = r_dividend;
        w_sq_next       = r_sq;
        w_sr_next       = r_sr;
        w_result_next   = r_result;
        w_op_done_next  = r_op_done;
        w_dbz_next      = r_dbz;

        if (op_clear) begin
            // Abort or acknowledge from any state. A simultaneous op_start
            // in IDLE is dropped.
            w_state_next   = S_IDLE;
            w_count_next   = '0;
            w_result_next  = '0;
            w_op_done_next = 1'b0;
            w_dbz_next     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        w_p_next        = '0;
                        w_q_next        = w_abs_dividend;
                        w_d_next        = w_abs_divisor;
                        w_dividend_next = dividend;
                        w_sq_next       = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        w_sr_next       = dividend[WIDTH-1];
                        w_count_next    = '0;
                        w_state_next    = S_CALC;
                    end
                end

                S_CALC: begin
                    if (r_d == '0) begin
                        w_result_next  = {r_dividend, {WIDTH{1'b1}}};
                        w_dbz_next     = 1'b1;
                        w_op_done_next = 1'b1;
                        w_state_next   = S_DONE;
                    end else begin
                        w_p_next = w_sum;
                        w_q_next = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                        if (r_count == LAST_ITER) begin
                            w_count_next = '0;
                            w_state_next = S_FIX;
                        end else begin
                            w_count_next = r_count + CW'(1);
                        end
                    end
                end

                S_FIX: begin
                    w_result_next  = {w_rem_signed, w_quot_signed};
                    w_op_done_next = 1'b1;
                    w_state_next   = S_DONE;
                end

                S_DONE: begin
                    // Hold the result until op_clear arrives.
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_d        <= '0;
            r_dividend <= '0;
            r_sq       <= 1'b0;
            r_sr       <= 1'b0;
            r_result   <= '0;
            r_op_done  <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_p        <= w_p_next;
            r_q        <= w_q_next;
            r_d        <= w_d_next;
            r_dividend <= w_dividend_next;
            r_sq       <= w_sq_next;
            r_sr       <= w_sr_next;
            r_result   <= w_result_next;
            r_op_done  <= w_op_done_next;
            r_dbz      <= w_dbz_next;
        end
    end

    assign result      = r_result;
    assign op_done     = r_op_done;
    assign div_by_zero = r_dbz;

endmodule
